vs_bus_arbiter: RTL and testbench

- Owns the single serial link to the VS1003B decoder: pins XCS, XDCS, SI and SCLK.
- Shares the link between two requesters: a command requester (32-bit SCI writes, e.g. volume, mode, soft reset) and a data requester (16-bit SDI audio words from ROM).
- Arbitrates only at word boundaries and gates every word start on DREQ.
- Sits between the song/volume control logic and the decoder pins.

---
 rtl/vs_bus_pkg.sv | 14 +
 rtl/vs_half_timer.sv | 22 ++
 rtl/vs_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_vs_bus_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vs_bus_pkg.sv
// Shared types and constants for the VS1003B serial-link arbiter.
package vs_bus_pkg;

    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, HOLD, GAP} vs_state_t;

    localparam int SCI_BITS = 32;
    localparam int SDI_BITS = 16;

    localparam logic [7:0] SCI_WRITE = 8'h02;
    localparam logic [7:0] SCI_READ  = 8'h03;
    localparam logic [7:0] SCI_MODE  = 8'h00;
    localparam logic [7:0] SCI_VOL   = 8'h0B;

endpackage

// File: rtl/vs_half_timer.sv
// Half-period timer: expire pulses every HALF_CYCLES cycles while restart is low;
// the count wraps on expire so back-to-back phases chain without a lost cycle.
module vs_half_timer #(
    parameter int HALF_CYCLES = 50
) (
    input  logic CLK,
    input  logic RST,
    input  logic restart,
    output logic expire
);
    localparam int CW = $clog2(HALF_CYCLES + 1);

    logic [CW-1:0] cnt;

    assign expire = (cnt == CW'(HALF_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RST || restart || expire) cnt <= '0;
        else                          cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/vs_bus_arbiter.sv
// Word-boundary arbiter for the VS1003B SCI/SDI serial link (command has priority).
// Optional DREQ wait watchdog enabled by defining DREQ_TIMEOUT_EN.
module vs_bus_arbiter
    import vs_bus_pkg::*;
#(
    parameter int HALF_CYCLES    = 50,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        DREQ,
    input  logic        cmd_req,
    input  logic [31:0] cmd_word,
    output logic        cmd_ack,
    input  logic        data_req,
    input  logic [15:0] data_word,
    output logic        data_ack,
    output logic        XCS,
    output logic        XDCS,
    output logic        SI,
    output logic        SCLK,
`ifdef DREQ_TIMEOUT_EN
    output logic        err_timeout,
`endif
    output logic        busy
);
    if (HALF_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("vs_bus_arbiter: HALF_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    vs_state_t   state;
    logic        dreq_meta, dreq_s;
    logic [31:0] sr;
    logic [5:0]  bits_left;
    logic        expire;

    always_ff @(posedge CLK) begin
        if (RST) begin
            dreq_meta <= 1'b0;
            dreq_s    <= 1'b0;
        end else begin
            dreq_meta <= DREQ;
            dreq_s    <= dreq_meta;
        end
    end

    vs_half_timer #(.HALF_CYCLES(HALF_CYCLES)) u_timer (
        .CLK     (CLK),
        .RST     (RST),
        .restart (state == IDLE),
        .expire  (expire)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            XCS       <= 1'b1;
            XDCS      <= 1'b1;
            SCLK      <= 1'b0;
            SI        <= 1'b0;
            cmd_ack   <= 1'b0;
            data_ack  <= 1'b0;
            sr        <= '0;
            bits_left <= '0;
        end else begin
            cmd_ack  <= 1'b0;
            data_ack <= 1'b0;
            case (state)
                IDLE: if (dreq_s) begin
                    // SI is loaded with the MSB here; sr holds the bits still to go.
                    if (cmd_req) begin
                        sr        <= {cmd_word[SCI_BITS-2:0], 1'b0};
                        SI        <= cmd_word[SCI_BITS-1];
                        bits_left <= 6'(SCI_BITS);
                        XCS       <= 1'b0;
                        cmd_ack   <= 1'b1;
                        state     <= SHIFT_LO;
                    end else if (data_req) begin
                        sr        <= {data_word[SDI_BITS-2:0], 17'b0};
                        SI        <= data_word[SDI_BITS-1];
                        bits_left <= 6'(SDI_BITS);
                        XDCS      <= 1'b0;
                        data_ack  <= 1'b1;
                        state     <= SHIFT_LO;
                    end
                end
                SHIFT_LO: if (expire) begin
                    SCLK  <= 1'b1;
                    state <= SHIFT_HI;
                end
                SHIFT_HI: if (expire) begin
                    SCLK <= 1'b0;
                    if (bits_left == 6'd1) begin
                        state <= HOLD;
                    end else begin
                        SI        <= sr[31];
                        sr        <= {sr[30:0], 1'b0};
                        bits_left <= bits_left - 6'd1;
                        state     <= SHIFT_LO;
                    end
                end
                HOLD: if (expire) begin
                    XCS   <= 1'b1;
                    XDCS  <= 1'b1;
                    SI    <= 1'b0;
                    state <= GAP;
                end
                GAP: if (expire) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DREQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;

    // Watchdog only flags the stall; the pending request keeps waiting.
    always_ff @(posedge CLK) begin
        if (RST) begin
            to_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= 1'b0;
            if (state == IDLE && !dreq_s && (cmd_req || data_req)) begin
                if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    to_cnt      <= '0;
                    err_timeout <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + TW'(1);
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vs_bus_arbiter.sv
// Scoreboard bench for vs_bus_arbiter: frames are decoded from the pins and matched
// against expected words queued when the requests are issued.
module tb_vs_bus_arbiter;
    import vs_bus_pkg::*;

    localparam int H        = 2;
    localparam int LEN_CMD  = 32 * 2 * H + H;
    localparam int LEN_DATA = 16 * 2 * H + H;

    logic        CLK, RST, DREQ;
    logic        cmd_req, cmd_ack, data_req, data_ack;
    logic [31:0] cmd_word;
    logic [15:0] data_word;
    logic        XCS, XDCS, SI, SCLK, busy;
`ifdef DREQ_TIMEOUT_EN
    logic        err_timeout;
`endif

    vs_bus_arbiter #(.HALF_CYCLES(H), .TIMEOUT_CYCLES(50)) dut (
        .CLK(CLK), .RST(RST), .DREQ(DREQ),
        .cmd_req(cmd_req), .cmd_word(cmd_word), .cmd_ack(cmd_ack),
        .data_req(data_req), .data_word(data_word), .data_ack(data_ack),
        .XCS(XCS), .XDCS(XDCS), .SI(SI), .SCLK(SCLK),
`ifdef DREQ_TIMEOUT_EN
        .err_timeout(err_timeout),
`endif
        .busy(busy)
    );

    typedef struct { bit is_cmd; logic [31:0] word; int nbits; int len; int start; } frame_t;
    typedef struct { bit is_cmd; logic [31:0] word; } exp_t;

    frame_t      obs_q[$];
    exp_t        exp_q[$];
    logic [31:0] cmd_in_q[$];
    logic [15:0] data_in_q[$];

    int checks = 0, errors = 0;
    int cyc = 0, overlap_cnt = 0, n_cmd_ack = 0, n_data_ack = 0;
    bit in_frame = 0;
    frame_t cur;
    logic prev_sclk = 0;

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    // Pin monitor: rebuilds each chip-select frame from SI sampled on SCLK rises.
    always @(negedge CLK) begin
        cyc++;
        if (cmd_ack === 1'b1) n_cmd_ack++;
        if (data_ack === 1'b1) n_data_ack++;
        if (XCS === 1'b0 && XDCS === 1'b0) overlap_cnt++;
        if (XCS === 1'b0 || XDCS === 1'b0) begin
            if (!in_frame) begin
                in_frame = 1; cur.is_cmd = (XCS === 1'b0); cur.word = '0;
                cur.nbits = 0; cur.len = 0; cur.start = cyc;
            end
            cur.len++;
            if (SCLK === 1'b1 && prev_sclk === 1'b0) begin
                cur.word = {cur.word[30:0], SI};
                cur.nbits++;
            end
        end else if (in_frame) begin
            in_frame = 0;
            obs_q.push_back(cur);
        end
        prev_sclk = SCLK;
    end

    // Requesters: hold req while words are queued, advance on ack.
    initial begin
        logic [31:0] t;
        cmd_req = 0; cmd_word = '0;
        forever begin
            @(negedge CLK);
            if (cmd_ack === 1'b1 && cmd_in_q.size() > 0) t = cmd_in_q.pop_front();
            if (cmd_in_q.size() > 0) begin cmd_req = 1; cmd_word = cmd_in_q[0]; end
            else cmd_req = 0;
        end
    end

    initial begin
        logic [15:0] t;
        data_req = 0; data_word = '0;
        forever begin
            @(negedge CLK);
            if (data_ack === 1'b1 && data_in_q.size() > 0) t = data_in_q.pop_front();
            if (data_in_q.size() > 0) begin data_req = 1; data_word = data_in_q[0]; end
            else data_req = 0;
        end
    end

    task automatic wait_obs(input int n);
        int t = 0;
        while (obs_q.size() < n && t < 3000) begin @(negedge CLK); t++; end
    endtask

    task automatic push_cmd(input logic [31:0] w);
        exp_t e; e.is_cmd = 1; e.word = w; exp_q.push_back(e); cmd_in_q.push_back(w);
    endtask

    task automatic push_data(input logic [15:0] w);
        exp_t e; e.is_cmd = 0; e.word = {16'h0, w}; exp_q.push_back(e); data_in_q.push_back(w);
    endtask

    task automatic test_reset();
        RST = 1; DREQ = 0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({XCS, XDCS, SCLK, SI, cmd_ack, data_ack, busy} !== 7'b1100000) begin
            errors++;
            $display("FAIL reset_state: got XCS,XDCS,SCLK,SI,cack,dack,busy=%b want 1100000",
                     {XCS, XDCS, SCLK, SI, cmd_ack, data_ack, busy});
        end
        RST = 0; DREQ = 1;
        repeat (4) @(negedge CLK);
        checks++;
        if (busy !== 1'b0 || n_cmd_ack + n_data_ack != 0) begin
            errors++; $display("FAIL idle_no_req: busy=%b acks=%0d want 0/0", busy, n_cmd_ack + n_data_ack);
        end
    endtask

    task automatic test_cmd_single();
        frame_t f; exp_t e; int a0 = n_cmd_ack;
        push_cmd({SCI_WRITE, SCI_VOL, 16'h2020});
        wait_obs(1);
        checks++;
        if (obs_q.size() == 0) begin errors++; $display("FAIL cmd_frame: no frame seen"); end
        else begin
            f = obs_q.pop_front(); e = exp_q.pop_front();
            if (f.is_cmd !== e.is_cmd || f.word !== e.word || f.nbits != 32 || f.len != LEN_CMD) begin
                errors++;
                $display("FAIL cmd_frame: got cmd=%0b word=%h bits=%0d len=%0d want cmd=%0b word=%h bits=32 len=%0d",
                         f.is_cmd, f.word, f.nbits, f.len, e.is_cmd, e.word, LEN_CMD);
            end
        end
        checks++;
        if (n_cmd_ack - a0 != 1) begin errors++; $display("FAIL cmd_ack_count: got %0d want 1", n_cmd_ack - a0); end
    endtask

    task automatic test_back_to_back();
        frame_t f; exp_t e; int st[2]; int d0 = n_data_ack;
        push_data(16'hA55A); push_data(16'h0F0F);
        wait_obs(2);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_q.size() == 0) begin errors++; st[i] = 0; $display("FAIL b2b_frame%0d: no frame seen", i); end
            else begin
                f = obs_q.pop_front(); e = exp_q.pop_front(); st[i] = f.start;
                if (f.is_cmd !== e.is_cmd || f.word !== e.word || f.nbits != 16 || f.len != LEN_DATA) begin
                    errors++;
                    $display("FAIL b2b_frame%0d: got cmd=%0b word=%h bits=%0d len=%0d want cmd=%0b word=%h bits=16 len=%0d",
                             i, f.is_cmd, f.word, f.nbits, f.len, e.is_cmd, e.word, LEN_DATA);
                end
            end
        end
        checks++;
        if (st[1] - st[0] != LEN_DATA + H + 1) begin
            errors++; $display("FAIL b2b_period: got %0d want %0d", st[1] - st[0], LEN_DATA + H + 1);
        end
        checks++;
        if (n_data_ack - d0 != 2) begin errors++; $display("FAIL b2b_acks: got %0d want 2", n_data_ack - d0); end
    endtask

    task automatic test_priority();
        frame_t f; exp_t e; int t;
        // Both at once: command wins, data follows.
        push_cmd({SCI_WRITE, SCI_MODE, 16'h0800});
        push_data(16'h1357);
        wait_obs(2);
        // Command arriving mid-data-frame waits for the word boundary.
        push_data(16'hBEEF);
        t = 0;
        while (!(in_frame && !cur.is_cmd) && t < 500) begin @(negedge CLK); t++; end
        repeat (10) @(negedge CLK);
        push_cmd({SCI_WRITE, SCI_VOL, 16'h4040});
        wait_obs(4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL prio_frame%0d: no frame seen", i); end
            else begin
                f = obs_q.pop_front(); e = exp_q.pop_front();
                if (f.is_cmd !== e.is_cmd || f.word !== e.word || f.len != (e.is_cmd ? LEN_CMD : LEN_DATA)) begin
                    errors++;
                    $display("FAIL prio_frame%0d: got cmd=%0b word=%h len=%0d want cmd=%0b word=%h len=%0d",
                             i, f.is_cmd, f.word, f.len, e.is_cmd, e.word, e.is_cmd ? LEN_CMD : LEN_DATA);
                end
            end
        end
    endtask

    task automatic test_dreq_stall();
        frame_t f; exp_t e; int t = 0, bad = 0, lat = 0, d0;
`ifdef DREQ_TIMEOUT_EN
        int pulses = 0;
`endif
        while (busy !== 1'b0 && t < 500) begin @(negedge CLK); t++; end
        DREQ = 0;
        repeat (5) @(negedge CLK);
        d0 = n_data_ack;
        push_data(16'h1234);
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (data_ack !== 1'b0 || busy !== 1'b0) bad++;
`ifdef DREQ_TIMEOUT_EN
            if (i < 180 && err_timeout === 1'b1) pulses++;
`endif
        end
        checks++;
        if (bad != 0 || n_data_ack != d0) begin
            errors++; $display("FAIL stall_idle: got %0d busy/ack cycles, %0d acks want 0/0", bad, n_data_ack - d0);
        end
`ifdef DREQ_TIMEOUT_EN
        checks++;
        if (pulses != 3) begin errors++; $display("FAIL timeout_pulses: got %0d want 3", pulses); end
`endif
        DREQ = 1;
        do begin @(negedge CLK); lat++; end while (data_ack !== 1'b1 && lat < 10);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL dreq_grant_latency: got %0d want 3", lat); end
        wait_obs(1);
        checks++;
        if (obs_q.size() == 0) begin errors++; $display("FAIL stall_frame: no frame seen"); end
        else begin
            f = obs_q.pop_front(); e = exp_q.pop_front();
            if (f.is_cmd !== e.is_cmd || f.word !== e.word || f.len != LEN_DATA) begin
                errors++;
                $display("FAIL stall_frame: got cmd=%0b word=%h len=%0d want cmd=%0b word=%h len=%0d",
                         f.is_cmd, f.word, f.len, e.is_cmd, e.word, LEN_DATA);
            end
        end
    endtask

    task automatic test_reset_mid();
        frame_t f; exp_t e; int t = 0, a0;
        logic [31:0] w;
        w = {SCI_WRITE, SCI_MODE, 16'h0804};
        while (busy !== 1'b0 && t < 500) begin @(negedge CLK); t++; end
        a0 = n_cmd_ack;
        cmd_in_q.push_back(w);   // attempt that gets reset away
        push_cmd(w);             // requester still asking after reset
        t = 0;
        while (!(in_frame && cur.is_cmd && cur.nbits == 10) && t < 500) begin @(negedge CLK); t++; end
        RST = 1;
        @(negedge CLK);
        checks++;
        if ({XCS, XDCS, SCLK, SI, busy} !== 5'b11000) begin
            errors++; $display("FAIL reset_mid_pins: got XCS,XDCS,SCLK,SI,busy=%b want 11000", {XCS, XDCS, SCLK, SI, busy});
        end
        RST = 0;
        wait_obs(2);
        checks++;
        if (obs_q.size() < 2) begin errors++; $display("FAIL reset_mid_frames: got %0d frames want 2", obs_q.size()); end
        else begin
            f = obs_q.pop_front();
            if (!f.is_cmd || f.nbits != 10) begin
                errors++; $display("FAIL reset_mid_abort: got cmd=%0b bits=%0d want cmd=1 bits=10", f.is_cmd, f.nbits);
            end
            checks++;
            f = obs_q.pop_front(); e = exp_q.pop_front();
            if (f.is_cmd !== e.is_cmd || f.word !== e.word || f.nbits != 32 || f.len != LEN_CMD) begin
                errors++;
                $display("FAIL reset_mid_resend: got cmd=%0b word=%h bits=%0d len=%0d want cmd=1 word=%h bits=32 len=%0d",
                         f.is_cmd, f.word, f.nbits, f.len, e.word, LEN_CMD);
            end
        end
        checks++;
        if (n_cmd_ack - a0 != 2) begin errors++; $display("FAIL reset_mid_acks: got %0d want 2", n_cmd_ack - a0); end
    endtask

    task automatic test_dreq_drop();
        frame_t f; exp_t e; int t = 0, d0 = n_data_ack;
        push_data(16'hC3C3); push_data(16'h3C3C);
        while (!(in_frame && !cur.is_cmd && cur.nbits == 4) && t < 500) begin @(negedge CLK); t++; end
        DREQ = 0;
        wait_obs(1);
        repeat (30) @(negedge CLK);
        checks++;
        if (obs_q.size() != 1 || in_frame || busy !== 1'b0 || n_data_ack - d0 != 1) begin
            errors++;
            $display("FAIL dreq_drop_hold: got frames=%0d busy=%b acks=%0d want 1/0/1", obs_q.size(), busy, n_data_ack - d0);
        end
        DREQ = 1;
        wait_obs(2);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL dreq_drop_frame%0d: no frame seen", i); end
            else begin
                f = obs_q.pop_front(); e = exp_q.pop_front();
                if (f.is_cmd !== e.is_cmd || f.word !== e.word || f.len != LEN_DATA) begin
                    errors++;
                    $display("FAIL dreq_drop_frame%0d: got cmd=%0b word=%h len=%0d want cmd=%0b word=%h len=%0d",
                             i, f.is_cmd, f.word, f.len, e.is_cmd, e.word, LEN_DATA);
                end
            end
        end
    endtask

    task automatic test_final();
        repeat (10) @(negedge CLK);
        checks++;
        if (overlap_cnt != 0) begin errors++; $display("FAIL cs_exclusive: got %0d overlap cycles want 0", overlap_cnt); end
        checks++;
        if (exp_q.size() != 0 || obs_q.size() != 0 || cmd_in_q.size() != 0 || data_in_q.size() != 0) begin
            errors++;
            $display("FAIL queues_drained: exp=%0d obs=%0d cmd=%0d data=%0d want all 0",
                     exp_q.size(), obs_q.size(), cmd_in_q.size(), data_in_q.size());
        end
    endtask

    initial begin
        RST = 1; DREQ = 0;
        test_reset();
        test_cmd_single();
        test_back_to_back();
        test_priority();
        test_dreq_stall();
        test_reset_mid();
        test_dreq_drop();
        test_final();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
